// File: rtl/gate_tester.sv
// Stimulus/check end of a 2-input gate interface: walks AB through 00..11,
// holds each vector SETTLE cycles, samples F and scores it against FUNC.
module gate_tester #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] FUNC,
  input  logic       F,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_VEC,
  output logic [2:0] FAIL_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] func_q, func_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0] err_vec_q, err_vec_d;
  logic [2:0] fail_cnt_q, fail_cnt_d;

  logic       exp_f, mismatch;
  logic [1:0] idx_nxt;

  // Reference truth table evaluated on the vector currently applied.
  always_comb begin
    exp_f = 1'b0;
    case (func_q)
      2'b00: exp_f =   idx_q[1] & idx_q[0];
      2'b01: exp_f =   idx_q[1] | idx_q[0];
      2'b10: exp_f =   idx_q[1] ^ idx_q[0];
      2'b11: exp_f = ~(idx_q[1] & idx_q[0]);
      default: exp_f = 1'b0;
    endcase
  end

  assign mismatch = (F != exp_f);
  assign idx_nxt  = idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_vec_d  = err_vec_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          func_d     = FUNC;
          idx_d      = 2'd0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          cnt_d      = 8'd0;
          err_vec_d  = 4'd0;
          fail_cnt_d = 3'd0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_vec_d[idx_q] = 1'b1;
          fail_cnt_d       = fail_cnt_q + 3'd1;
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_nxt;
          a_d     = idx_nxt[1];
          b_d     = idx_nxt[0];
          cnt_d   = 8'd0;
          state_d = S_SETTLE;
        end else begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // last sample counts too, so fold it in alongside the running total
          pass_d  = !mismatch && (fail_cnt_q == 3'd0);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      func_q     <= 2'd0;
      idx_q      <= 2'd0;
      cnt_q      <= 8'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_vec_q  <= 4'd0;
      fail_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_vec_q  <= err_vec_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_VEC  = err_vec_q;
  assign FAIL_CNT = fail_cnt_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: models the gate under test, queues expected run
// results at START and scores them when DONE appears.
module tb_gate_tester;

  logic       CLK = 1'b0;
  logic       RST, START;
  logic [1:0] FUNC;
  logic       F;
  logic       A, B, BUSY, DONE, PASS;
  logic [3:0] ERR_VEC;
  logic [2:0] FAIL_CNT;

  int gate_mode;  // 0: real AND gate, 1: F tied 1, 2: F tied 0
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] err_vec;
    logic [2:0] fail_cnt;
    logic       pass;
  } result_t;

  result_t sb[$];

  gate_tester #(.SETTLE(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .FUNC(FUNC), .F(F),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .ERR_VEC(ERR_VEC), .FAIL_CNT(FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    F = 1'b0;
    case (gate_mode)
      0: F = A & B;
      1: F = 1'b1;
      default: F = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic result_t model(input logic [1:0] fn, input int mode);
    result_t r;
    logic a, b, f, e;
    r.err_vec  = 4'd0;
    r.fail_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      a = (i >> 1) & 1;
      b = i & 1;
      f = (mode == 0) ? (a & b) : (mode == 1);
      case (fn)
        2'b00:   e = a & b;
        2'b01:   e = a | b;
        2'b10:   e = a ^ b;
        default: e = ~(a & b);
      endcase
      if (f != e) begin
        r.err_vec[i] = 1'b1;
        r.fail_cnt   = r.fail_cnt + 3'd1;
      end
    end
    r.pass = (r.fail_cnt == 3'd0);
    return r;
  endfunction

  // variant 0: plain run; 1: START re-pulsed at edges 3/8 and FUNC toggled;
  // 2: RST asserted at edge 10 (run aborted, expected entry discarded).
  task automatic run_one(input logic [1:0] fn, input int mode, input int variant);
    result_t e, got;
    int done_cnt, last;
    gate_mode = mode;
    e = model(fn, mode);
    sb.push_back(e);
    FUNC  = fn;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("clr_pass", PASS, 0);
    chk("clr_err", ERR_VEC, 0);
    chk("clr_fcnt", FAIL_CNT, 0);
    done_cnt = 0;
    last = (variant == 2) ? 40 : 30;
    for (int c = 0; c <= last; c++) begin
      if (variant == 2 && c == 10) begin
        chk("rst_a", A, 0);
        chk("rst_b", B, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_pass", PASS, 0);
        chk("rst_err", ERR_VEC, 0);
        chk("rst_fcnt", FAIL_CNT, 0);
        RST = 1'b0;
        void'(sb.pop_back());
      end
      if (c < 20 && !(variant == 2 && c >= 10)) begin
        chk("busy", BUSY, 1);
        chk("a", A, ((c / 5) >> 1) & 1);
        chk("b", B, (c / 5) & 1);
        chk("done_early", DONE, 0);
      end
      if (DONE) done_cnt++;
      if (c == 20 && variant != 2) begin
        chk("done", DONE, 1);
        chk("busy_end", BUSY, 0);
        chk("a_end", A, 0);
        chk("b_end", B, 0);
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("pass", PASS, got.pass);
          chk("err_vec", ERR_VEC, got.err_vec);
          chk("fail_cnt", FAIL_CNT, got.fail_cnt);
        end
      end
      if (c > 20 && variant != 2) begin
        chk("hold_pass", PASS, e.pass);
        chk("hold_err", ERR_VEC, e.err_vec);
        chk("hold_fcnt", FAIL_CNT, e.fail_cnt);
        chk("idle_busy", BUSY, 0);
      end
      START = (variant == 1) && (c + 1 == 3 || c + 1 == 8);
      if (variant == 1 && c == 5)  FUNC = ~fn;
      if (variant == 1 && c == 12) FUNC = 2'b01;
      if (variant == 2 && c + 1 == 10) RST = 1'b1;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    chk("done_count", done_cnt, (variant == 2) ? 0 : 1);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; FUNC = 2'b00; gate_mode = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_a", A, 0);
    chk("reset_b", B, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_pass", PASS, 0);
    chk("reset_err", ERR_VEC, 0);
    chk("reset_fcnt", FAIL_CNT, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_one(2'b00, 0, 0);  // AND vs AND gate: pass
    run_one(2'b01, 0, 0);  // OR vs AND gate: 0110
    run_one(2'b11, 1, 0);  // NAND vs tied 1: 1000
    run_one(2'b10, 2, 0);  // XOR vs tied 0: 0110, then held
    run_one(2'b00, 0, 0);  // results cleared at START, then pass
    run_one(2'b00, 0, 1);  // ignored re-START and FUNC changes
    run_one(2'b01, 0, 2);  // aborted by RST
    run_one(2'b00, 0, 0);  // normal run after abort

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_tester.md
Name: gate_tester

Overview:
Sequential exerciser for the kit's 2-input combinational gate blocks. It acts as the stimulus/checking end of the gate interface: it drives the gate's inputs A and B, samples the gate's output F, and compares F against a selected expected truth table. It sits on the board beside the gate under test, started from a pushbutton (already debounced and pulsed) and reporting results on LEDs.

Parameters:
SETTLE, 4, number of clock cycles A/B are held before F is sampled for each vector; legal range 1..255

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
START  input  1  begin test run; sampled only in IDLE
FUNC  input  2  expected function: 00 AND, 01 OR, 10 XOR, 11 NAND
F  input  1  output of the gate under test
A  output  1  gate input A (registered)
B  output  1  gate input B (registered)
BUSY  output  1  high while a run is in progress
DONE  output  1  one-cycle pulse at the end of a run
PASS  output  1  1 = all four vectors matched; valid from DONE until the next accepted START
ERR_VEC  output  4  bit i set if vector i mismatched, where i = {A,B}
FAIL_CNT  output  3  number of mismatching vectors, 0..4

Behaviour:
- One clock domain, CLK. RST is synchronous and active-high.
- RST takes priority over everything. On RST: state=IDLE; A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_VEC=0, FAIL_CNT=0; internal index and settle counter are 0.
- Asserting RST mid-run aborts the run immediately. No DONE pulse is produced.
- All outputs are registered.
- States:
  - IDLE. If START=1 at an edge: latch FUNC into an internal register, set idx=0, A=0, B=0, cnt=0, and clear ERR_VEC, FAIL_CNT and PASS. Set BUSY=1 and go to SETTLE.
  - SETTLE. cnt increments each cycle. At the edge where cnt==SETTLE-1, go to SAMPLE.
  - SAMPLE. Lasts one cycle. Compute expected = FUNC_latched(idx[1], idx[0]). If F != expected: set ERR_VEC[idx] and increment FAIL_CNT.
    - If idx<3: set idx=idx+1, A=idx_next[1], B=idx_next[0], cnt=0, and go to SETTLE.
    - If idx==3: set A=0, B=0, BUSY=0, DONE=1, and PASS=1 only if no mismatch occurred, including this sample. Go to IDLE.
- DONE is high for exactly one cycle. It clears at the next edge unless RST is asserted.
- Timing: each vector occupies SETTLE+1 cycles. If START is accepted at edge 0, DONE is high during the cycle following edge 4*(SETTLE+1). With SETTLE=4 that is edge 20.
- START while BUSY=1 is ignored. FUNC changes during a run are ignored because FUNC is latched.
- START sampled in IDLE during the DONE cycle is accepted, giving a back-to-back run. Holding START high therefore causes continuous runs.
- PASS, ERR_VEC and FAIL_CNT hold their values after a run until the next accepted START or RST.
- Vector order is AB = 00, 01, 10, 11. F is sampled combinationally from the registered A/B, so the gate itself adds no latency.

Test Plan:
- FUNC=00, F driven by a real AND of A,B, SETTLE=4, START pulse at edge 0 → A,B step 00,01,10,11 at 5-cycle spacing; DONE at edge 20; PASS=1, ERR_VEC=0000, FAIL_CNT=0, BUSY low from edge 20.
- FUNC=01 (OR), F from an AND gate → mismatches on vectors 01 and 10; ERR_VEC=0110, FAIL_CNT=2, PASS=0.
- FUNC=11 (NAND), F tied 1 → mismatch only on vector 11; ERR_VEC=1000, FAIL_CNT=1, PASS=0.
- Run with FUNC=10 (XOR) and F tied 0 → ERR_VEC=0110, FAIL_CNT=2. Hold PASS/ERR_VEC for 10 idle cycles and check they are stable. Issue a new START with FUNC=00 and an AND gate → results cleared at the START edge, then PASS=1.
- START re-pulsed at edges 3 and 8, and FUNC toggled mid-run → exactly one DONE at edge 20; results reflect the FUNC latched at edge 0.
- RST asserted at edge 10 of a run → next cycle all outputs 0, state IDLE; no DONE within 30 cycles. A subsequent START completes normally with DONE 20 cycles later.
